prio_arbiter_n: RTL and testbench



---
 rtl/prio_arbiter_n.sv | 106 ++++++++++
 tb/tb_prio_arbiter_n.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_arbiter_n.sv
// rtl/prio_arbiter_n.sv - registered N-way priority/round-robin arbiter with sticky grant
module prio_arbiter_n #(
    parameter int  N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         rr_en,
    input  logic         ack,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_onehot,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;

    localparam logic [W-1:0] PTR_TOP = W'(N - 1);
    localparam logic [N-1:0] ONE_N   = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]   state;
    logic [W-1:0] ptr;
    logic [W-1:0] ptr_next;
    logic [W-1:0] arb_ptr;
    logic [W-1:0] pos;
    logic [W-1:0] win_idx;
    logic         win_found;
    logic [N-1:0] win_onehot;

    // Pointer value that follows acceptance of the currently held grant.
    always_comb begin
        ptr_next = (grant_idx == '0) ? PTR_TOP : grant_idx - W'(1);
    end

    // On an ack in GRANT the search must already use the post-ack pointer.
    always_comb begin
        arb_ptr = (state == ST_GRANT) ? ptr_next : ptr;
    end

    // Downward circular search: starts at N-1 (fixed) or at the pointer (round-robin).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = rr_en ? arb_ptr : PTR_TOP;
        for (int k = 0; k < N; k++) begin
            if (!win_found && req[pos]) begin
                win_found = 1'b1;
                win_idx   = pos;
            end
            pos = (pos == '0) ? PTR_TOP : pos - W'(1);
        end
    end

    // One-hot form of the search result, registered alongside the index.
    always_comb begin
        win_onehot = ONE_N << win_idx;
    end

    // Grant registers, pointer and two-state control; stray encodings fall back to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            ptr          <= PTR_TOP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        state        <= ST_GRANT;
                        grant_valid  <= 1'b1;
                        grant_idx    <= win_idx;
                        grant_onehot <= win_onehot;
                    end
                end
                ST_GRANT: begin
                    if (ack) begin
                        ptr <= ptr_next;
                        if (win_found) begin
                            grant_idx    <= win_idx;
                            grant_onehot <= win_onehot;
                        end else begin
                            state        <= ST_IDLE;
                            grant_valid  <= 1'b0;
                            grant_idx    <= '0;
                            grant_onehot <= '0;
                        end
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    grant_valid  <= 1'b0;
                    grant_idx    <= '0;
                    grant_onehot <= '0;
                end
            endcase
        end
    end

    // Activity flag for power/clock management: pending requests or a live grant.
    assign busy = (|req) | grant_valid;

endmodule

// File: tb/tb_prio_arbiter_n.sv
// tb/tb_prio_arbiter_n.sv - self-checking bench for prio_arbiter_n
module tb_prio_arbiter_n;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       rr_en;
    logic       ack;
    logic       g_valid;
    logic [2:0] g_idx;
    logic [7:0] g_oh;
    logic       g_busy;

    logic [4:0] req5;
    logic       rr5;
    logic       ack5;
    logic       g5_valid;
    logic [2:0] g5_idx;
    logic [4:0] g5_oh;
    logic       g5_busy;

    int vectors;
    int miscompares;

    int m_valid;
    int m_idx;
    int m_ptr;

    prio_arbiter_n #(.N(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .rr_en        (rr_en),
        .ack          (ack),
        .grant_valid  (g_valid),
        .grant_idx    (g_idx),
        .grant_onehot (g_oh),
        .busy         (g_busy)
    );

    prio_arbiter_n #(.N(5)) dut5 (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req5),
        .rr_en        (rr5),
        .ack          (ack5),
        .grant_valid  (g5_valid),
        .grant_idx    (g5_idx),
        .grant_onehot (g5_oh),
        .busy         (g5_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_winner(input logic [7:0] r, input logic rr, input int p);
        if (!rr) begin
            for (int i = 7; i >= 0; i--)
                if (((r >> i) & 8'h01) != 8'h00) return i;
        end else begin
            for (int d = 0; d < 8; d++) begin
                int i;
                i = (p - d + 8) % 8;
                if (((r >> i) & 8'h01) != 8'h00) return i;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 7;
    endtask

    task automatic tick();
        @(posedge clk);
        if (m_valid == 0) begin
            if (req != 8'h00) begin
                m_valid = 1;
                m_idx   = model_winner(req, rr_en, m_ptr);
            end
        end else if (ack) begin
            m_ptr = (m_idx == 0) ? 7 : m_idx - 1;
            if (req != 8'h00) begin
                m_idx = model_winner(req, rr_en, m_ptr);
            end else begin
                m_valid = 0;
                m_idx   = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        req   = 8'h00;
        rr_en = 1'b0;
        ack   = 1'b0;
        req5  = 5'h00;
        rr5   = 1'b0;
        ack5  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 8'hFF;
        rr_en = 1'b0;
        ack   = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        vectors++;
        if (g_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %0b expected 0", g_valid);
        end
        vectors++;
        if (g_oh !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_onehot: got %h expected 00", g_oh);
        end
        vectors++;
        if (g_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_busy: got %0b expected 1", g_busy);
        end
        rst_n = 1'b1;
        tick();
        vectors++;
        if (g_idx !== 3'd7 || g_oh !== 8'h80 || g_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_grant: got idx %0d oh %h v %0b expected idx 7 oh 80 v 1",
                     g_idx, g_oh, g_valid);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        req = 8'b0010_0110;
        tick();
        vectors++;
        if (g_idx !== 3'd5 || g_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL fixed_first: got idx %0d v %0b expected idx 5 v 1", g_idx, g_valid);
        end
        ack = 1'b1;
        tick();
        vectors++;
        if (g_idx !== 3'd5) begin
            miscompares++;
            $display("FAIL fixed_repeat: got %0d expected 5", g_idx);
        end
        req = 8'b0000_0110;
        tick();
        vectors++;
        if (g_idx !== 3'd2 || g_oh !== 8'h04) begin
            miscompares++;
            $display("FAIL fixed_drop: got idx %0d oh %h expected idx 2 oh 04", g_idx, g_oh);
        end
        ack = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        do_reset();
        rr_en = 1'b1;
        req   = 8'hFF;
        ack   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            vectors++;
            if (g_idx !== 3'(exp_seq[i]) || g_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL rr8_step%0d: got idx %0d v %0b expected idx %0d v 1",
                         i, g_idx, g_valid, exp_seq[i]);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_sticky();
        do_reset();
        req = 8'b0000_1000;
        tick();
        vectors++;
        if (g_idx !== 3'd3) begin
            miscompares++;
            $display("FAIL sticky_first: got %0d expected 3", g_idx);
        end
        req = 8'b1000_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (g_idx !== 3'd3 || g_oh !== 8'h08) begin
                miscompares++;
                $display("FAIL sticky_hold%0d: got idx %0d oh %h expected idx 3 oh 08", i, g_idx, g_oh);
            end
        end
        ack = 1'b1;
        tick();
        vectors++;
        if (g_idx !== 3'd7) begin
            miscompares++;
            $display("FAIL sticky_after_ack: got %0d expected 7", g_idx);
        end
        ack = 1'b0;
    endtask

    task automatic test_drain();
        do_reset();
        req = 8'b0001_0000;
        tick();
        vectors++;
        if (g_idx !== 3'd4) begin
            miscompares++;
            $display("FAIL drain_grant: got %0d expected 4", g_idx);
        end
        req = 8'h00;
        ack = 1'b1;
        tick();
        vectors++;
        if (g_valid !== 1'b0 || g_busy !== 1'b0 || g_oh !== 8'h00 || g_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL drain_release: got v %0b busy %0b oh %h idx %0d expected all 0",
                     g_valid, g_busy, g_oh, g_idx);
        end
        ack = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 8'b0100_0000;
        tick();
        vectors++;
        if (g_idx !== 3'd6 || g_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL async_grant: got idx %0d v %0b expected idx 6 v 1", g_idx, g_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (g_valid !== 1'b0 || g_idx !== 3'd0 || g_oh !== 8'h00) begin
            miscompares++;
            $display("FAIL async_clear: got v %0b idx %0d oh %h expected all 0", g_valid, g_idx, g_oh);
        end
        req = 8'h00;
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_rr_n5();
        int exp_seq [6] = '{4, 3, 2, 1, 0, 4};
        do_reset();
        rr5  = 1'b1;
        req5 = 5'h1F;
        ack5 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (g5_idx !== 3'(exp_seq[i]) || g5_oh !== (5'h01 << exp_seq[i])) begin
                miscompares++;
                $display("FAIL rr5_step%0d: got idx %0d oh %h expected idx %0d", i, g5_idx, g5_oh, exp_seq[i]);
            end
        end
        req5 = 5'h00;
        ack5 = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] exp_oh;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       req = 8'h00;
                1:       req = 8'h01 << $urandom_range(0, 7);
                default: req = 8'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) rr_en = ~rr_en;
            ack = ($urandom_range(0, 2) != 0);
            tick();
            exp_oh = (m_valid != 0) ? (8'h01 << m_idx) : 8'h00;
            vectors++;
            if (g_valid !== (m_valid != 0) || g_idx !== 3'(m_idx) || g_oh !== exp_oh) begin
                miscompares++;
                $display("FAIL random_%0d: got v %0b idx %0d oh %h expected v %0d idx %0d oh %h",
                         n, g_valid, g_idx, g_oh, m_valid, m_idx, exp_oh);
            end
            vectors++;
            if (g_busy !== ((req != 8'h00) || (m_valid != 0))) begin
                miscompares++;
                $display("FAIL random_busy_%0d: got %0b expected %0b", n, g_busy,
                         (req != 8'h00) || (m_valid != 0));
            end
        end
        ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        req   = 8'h00;
        rr_en = 1'b0;
        ack   = 1'b0;
        req5  = 5'h00;
        rr5   = 1'b0;
        ack5  = 1'b0;
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_fixed();
        test_round_robin();
        test_sticky();
        test_drain();
        test_async_reset();
        test_rr_n5();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
